// File: rtl/reaction_counter_pkg.sv
// Shared definitions for the reaction timer: FSM state encodings,
// parameter defaults and the stimulus-delay LFSR step function.
package reaction_counter_pkg;

  localparam int UNIT_TICKS_DEF = 2_500_000;
  localparam int DELAY_BASE_DEF = 20;

  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ARMED = 3'd2,
    DONE  = 3'd3,
    CHEAT = 3'd4
  } state_t;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never reaches 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/reaction_counter_tick_gen.sv
// Unit prescaler: one-cycle tick every UNIT_TICKS enabled cycles, restartable via clr.
module tick_gen
  import reaction_counter_pkg::*;
#(
  parameter int UNIT_TICKS = UNIT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // tick must not depend on clr: the FSM derives clr from tick on the arming edge.
  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/reaction_counter.sv
// Reaction-time game core: random pre-stimulus delay, then counts units
// until the player responds, flagging early presses and timeouts.
module reaction_counter
  import reaction_counter_pkg::*;
#(
  parameter int UNIT_TICKS = UNIT_TICKS_DEF,
  parameter int DELAY_BASE = DELAY_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       led,
  output logic [3:0] q,
  output logic       valid,
  output logic       cheat,
  output logic       timeout
);

  // Wide enough for DELAY_BASE plus the largest random offset (15).
  localparam int DW = $clog2(DELAY_BASE + 16) + 1;
  localparam logic [DW-1:0] D_ONE = DW'(1);

  state_t        state;
  logic [DW-1:0] delay;
  logic [7:0]    lfsr;
  logic          start_reg;
  logic          stop_reg;

  logic          start_rise;
  logic          stop_rise;
  logic          tick;
  logic          tick_en;
  logic          tick_clr;
  logic          idle_like;
  logic          arming;
  logic [DW-1:0] delay_load;

  assign start_rise = start & ~start_reg;
  assign stop_rise  = stop & ~stop_reg;
  assign idle_like  = (state == IDLE) || (state == DONE) || (state == CHEAT);
  assign arming     = (state == WAIT) && !stop_rise && tick && (delay <= D_ONE);
  assign tick_en    = (state == WAIT) || (state == ARMED);
  assign tick_clr   = (idle_like && start_rise) || arming;
  assign delay_load = DW'(DELAY_BASE) + DW'(lfsr[3:0]);

  tick_gen #(
    .UNIT_TICKS(UNIT_TICKS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (tick_en),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      led       <= 1'b0;
      q         <= 4'd0;
      valid     <= 1'b0;
      cheat     <= 1'b0;
      timeout   <= 1'b0;
      delay     <= '0;
      lfsr      <= LFSR_SEED;
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
    end else begin
      start_reg <= start;
      stop_reg  <= stop;
      lfsr      <= lfsr_step(lfsr);

      case (state)
        IDLE, DONE, CHEAT: begin
          if (start_rise) begin
            state   <= WAIT;
            delay   <= delay_load;
            led     <= 1'b0;
            valid   <= 1'b0;
            cheat   <= 1'b0;
            timeout <= 1'b0;
          end
        end

        WAIT: begin
          // An early press beats a coincident tick.
          if (stop_rise) begin
            state <= CHEAT;
            cheat <= 1'b1;
            valid <= 1'b0;
            q     <= 4'hF;
            led   <= 1'b0;
          end else if (tick) begin
            if (delay <= D_ONE) begin
              state <= ARMED;
              delay <= '0;
              led   <= 1'b1;
              q     <= 4'd0;
            end else begin
              delay <= delay - D_ONE;
            end
          end
        end

        ARMED: begin
          if (stop_rise) begin
            state <= DONE;
            valid <= 1'b1;
            led   <= 1'b0;
          end else if (tick) begin
            // Saturate rather than wrap: the 16th tick is a timeout.
            if (q == 4'hF) begin
              state   <= DONE;
              valid   <= 1'b1;
              timeout <= 1'b1;
              led     <= 1'b0;
            end else begin
              q <= q + 4'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_counter.sv
// Directed bench for reaction_counter with UNIT_TICKS=4, DELAY_BASE=2.
`timescale 1ns/1ps
module tb_reaction_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       led;
  logic [3:0] q;
  logic       valid;
  logic       cheat;
  logic       timeout;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] lfsr_m;
  int         d;
  int         c;
  logic       led_seen;

  reaction_counter #(
    .UNIT_TICKS(4),
    .DELAY_BASE(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .led    (led),
    .q      (q),
    .valid  (valid),
    .cheat  (cheat),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'h01, one step per clock.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'h01;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(output int dl);
    start = 1'b1;
    dl = 2 + int'(lfsr_m[3:0]);
    step(1);
    start = 1'b0;
  endtask

  // Counts cycles from WAIT entry until led rises; optionally pokes start mid-WAIT.
  task automatic wait_led(output int cyc, input bit poke);
    cyc = 0;
    while (!led && cyc < 300) begin
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      step(1);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step(2);
    chk("rst_led", led, 0);
    chk("rst_q", q, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cheat", cheat, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    step(2);

    // Normal round, stop 3 units after the lamp.
    do_start(d);
    chk("a_wait_led", led, 0);
    wait_led(c, 1'b0);
    chk("a_wait_len", c, 4 * d);
    chk("a_arm_q", q, 0);
    step(12);
    stop = 1'b1; step(1); stop = 1'b0;
    $display("round A: q=%0d valid=%0b led=%0b", q, valid, led);
    chk("a_q", q, 3);
    chk("a_valid", valid, 1);
    chk("a_led", led, 0);
    chk("a_timeout", timeout, 0);
    chk("a_cheat", cheat, 0);
    chk("a_fast", {30'd0, q[3:2]}, 0);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0; step(1);
    chk("a_done_stop_ign_q", q, 3);
    chk("a_done_stop_ign_valid", valid, 1);

    // Early press during WAIT.
    do_start(d);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    $display("round B: cheat=%0b q=%0h led=%0b", cheat, q, led);
    chk("b_cheat", cheat, 1);
    chk("b_q", q, 4'hF);
    chk("b_valid", valid, 0);
    chk("b_led", led, 0);
    led_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      led_seen = led_seen | led;
    end
    chk("b_led_never", led_seen, 0);
    do_start(d);
    chk("b_restart_cheat", cheat, 0);
    chk("b_restart_led", led, 0);

    // No response: timeout on the 16th tick.
    wait_led(c, 1'b0);
    chk("c_wait_len", c, 4 * d);
    step(63);
    chk("c_pre_q", q, 4'hF);
    chk("c_pre_led", led, 1);
    chk("c_pre_timeout", timeout, 0);
    step(1);
    $display("round C: q=%0h timeout=%0b valid=%0b led=%0b", q, timeout, valid, led);
    chk("c_q", q, 4'hF);
    chk("c_timeout", timeout, 1);
    chk("c_valid", valid, 1);
    chk("c_led", led, 0);

    // Stop coincident with the tick that would make q=6.
    do_start(d);
    wait_led(c, 1'b0);
    chk("d_wait_len", c, 4 * d);
    step(23);
    chk("d_pre_q", q, 5);
    stop = 1'b1; step(1); stop = 1'b0;
    $display("round D: q=%0d valid=%0b", q, valid);
    chk("d_q", q, 5);
    chk("d_valid", valid, 1);
    chk("d_led", led, 0);
    chk("d_timeout", timeout, 0);

    // Asynchronous reset mid-measurement.
    do_start(d);
    wait_led(c, 1'b0);
    step(24);
    chk("e_pre_q", q, 6);
    #2 rst = 1'b1;
    #1;
    $display("round E: async reset led=%0b q=%0d valid=%0b", led, q, valid);
    chk("e_rst_led", led, 0);
    chk("e_rst_q", q, 0);
    chk("e_rst_valid", valid, 0);
    chk("e_rst_cheat", cheat, 0);
    chk("e_rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    do_start(d);
    wait_led(c, 1'b0);
    chk("e_wait_len", c, 4 * d);
    step(4);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("e_q", q, 1);
    chk("e_valid", valid, 1);

    // Random delay over 8 rounds, with ignored start presses in WAIT and ARMED.
    for (int r = 0; r < 8; r++) begin
      do_start(d);
      wait_led(c, 1'b1);
      $display("round F%0d: delay=%0d wait=%0d", r, d, c);
      chk($sformatf("f%0d_wait_len", r), c, 4 * d);
      start = 1'b1; step(1); start = 1'b0;
      step(7);
      stop = 1'b1; step(1); stop = 1'b0;
      chk($sformatf("f%0d_q", r), q, 2);
      chk($sformatf("f%0d_valid", r), valid, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
